bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Iterative binary-to-BCD converter using shift-add-3 (double-dabble), one bit per clock.
//  Generalised to any input width and digit count.
//  Uses valid/ready handshakes on both input and output.
//  Sits between arithmetic datapaths and 7-segment or display drivers.
//  Trades the comparator-array area for BIN_W cycles of latency.
// PARAMETERS
//  BIN_W   8  binary input width in bits (>=2)
//  DIGITS  3  BCD output digits; bcd_out width is 4*DIGITS
// PORTS
//  clk        in   1         rising-edge clock (single clock domain)
//  rst_n      in   1         asynchronous active-low reset
//  in_valid   in   1         bin_in is valid
//  in_ready   out  1         converter can accept a value
//  bin_in     in   BIN_W     binary value
//  out_valid  out  1         bcd_out, ovf and out_neg are valid
//  out_ready  in   1         consumer accepts the result
//  bcd_out    out  4*DIGITS  packed BCD, digit 0 in [3:0]
//  ovf        out  1         value does not fit in DIGITS digits
//  out_neg    out  1         sign of the input; only meaningful with BCD_SIGNED_EN
// BEHAVIOUR
//  Reset: asynchronous, active-low. On assertion, immediately:
//   - state=IDLE, in_ready=1, out_valid=0
//   - bcd_out=0, ovf=0, out_neg=0
//   - internal shift and bit counters cleared
//  Reset mid-conversion aborts the conversion; no result is emitted.
//  FSM states: IDLE, SHIFT, DONE.
//  - IDLE: in_ready=1.
//    On in_valid&&in_ready, latch bin_in, clear the BCD accumulator and ovf,
//    load count=BIN_W-1, and go to SHIFT.
//  - SHIFT: in_ready=0. Each cycle:
//    (a) every 4-bit digit >=5 gets +3;
//    (b) {acc,bin} shifts left by 1; the bin MSB enters acc bit 0.
//    A 1 shifted out of acc MSB sets ovf (sticky).
//    When count==0, go to DONE; otherwise count decrements.
//  - DONE: out_valid=1. bcd_out, ovf and out_neg hold stable until out_valid&&out_ready.
//    On that handshake: out_valid=0, go to IDLE.
//    bcd_out keeps its last value; it is don't-care when out_valid=0.
//  Latency: out_valid rises exactly BIN_W rising edges after the acceptance edge.
//  Throughput: one conversion per BIN_W+2 cycles with out_ready tied high.
//  in_valid is ignored outside IDLE; there is no buffering, so the producer must hold.
//  out_ready is ignored outside DONE.
//  Overflow: bcd_out holds the low DIGITS digits of the true value and ovf=1.
//  Arithmetic: the add-3 is per digit and never carries between digits.
//  A digit value >9 never appears in a final result.
//  Count width is clog2(BIN_W).
// CONFIGURATION
//  BCD_SIGNED_EN defined:
//   - bin_in is two's complement.
//   - Magnitude = bin_in[BIN_W-1] ? -bin_in : bin_in, computed at acceptance.
//   - The most negative value gives magnitude 2^(BIN_W-1), converted as unsigned BIN_W bits.
//   - out_neg = bin_in[BIN_W-1], latched at acceptance.
//   - Latency is unchanged.
//  BCD_SIGNED_EN undefined:
//   - bin_in is unsigned.
//   - out_neg is tied to 0.
// TESTING
//  1. BIN_W=8, DIGITS=3: accept 8'd255 -> out_valid 8 edges later, bcd_out=12'h255, ovf=0.
//  2. Sweep 0..255 with out_ready=1 -> bcd_out matches a decimal model for every value.
//     Also check 0->12'h000 and 99->12'h099.
//  3. Backpressure: hold out_ready=0 for 5 cycles after out_valid.
//     -> outputs stable, in_ready=0, new in_valid ignored. Release -> IDLE, in_ready=1.
//  4. DIGITS=2: accept 200 -> bcd_out=8'h00, ovf=1.
//     Then accept 99 -> bcd_out=8'h99, ovf=0 (ovf cleared per conversion).
//  5. Pulse rst_n low 3 cycles into SHIFT -> out_valid=0, in_ready=1 immediately.
//     No out_valid until a new input is accepted.
//  6. BCD_SIGNED_EN: 8'h80 -> 12'h128, out_neg=1; 8'hF6 -> 12'h010, out_neg=1;
//     8'h7F -> 12'h127, out_neg=0.

Source files
------------

// File: rtl/bin2bcd_seq_if.sv
// Handshake bundle for bin2bcd_seq: input valid/ready with binary value, output valid/ready with BCD result.
// The converter takes the slave modport; the producer/consumer side takes master.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;
  logic                  out_neg;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, ovf, out_neg
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, ovf, out_neg
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock, valid/ready on both sides.
// Define BCD_SIGNED_EN to treat bin_in as two's complement and report its sign on out_neg.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  bin2bcd_seq_if.slave    bus
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_bin;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   w_acc_adj;
  logic [BIN_W-1:0]   w_mag;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_last;

`ifdef BCD_SIGNED_EN
  logic               r_neg;
  // Unary minus wraps the most negative value onto itself, which read unsigned is 2^(BIN_W-1).
  assign w_mag       = bus.bin_in[BIN_W-1] ? -bus.bin_in : bus.bin_in;
  assign bus.out_neg = r_neg;
`else
  assign w_mag       = bus.bin_in;
  assign bus.out_neg = 1'b0;
`endif

  assign w_last = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-digit add-3; digits never carry into each other.
  always_comb begin
    w_acc_adj = r_acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_acc_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
`ifdef BCD_SIGNED_EN
      r_neg <= 1'b0;
`endif
    end else if (w_accept) begin
      r_bin <= w_mag;
      r_acc <= '0;
      r_cnt <= CNT_W'(BIN_W - 1);
      r_ovf <= 1'b0;
`ifdef BCD_SIGNED_EN
      r_neg <= bus.bin_in[BIN_W-1];
`endif
    end else if (r_state == S_SHIFT) begin
      r_acc <= {w_acc_adj[ACC_W-2:0], r_bin[BIN_W-1]};
      r_bin <= {r_bin[BIN_W-2:0], 1'b0};
      r_ovf <= r_ovf | w_acc_adj[ACC_W-1];
      if (!w_last) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.bcd_out   = r_acc;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 3-digit and a 2-digit instance checked against a decimal model.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(3)) b3 ();
  bin2bcd_seq_if #(.BIN_W(8), .DIGITS(2)) b2 ();

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd;
    logic        ovf;
    logic        neg;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Decimal reference: magnitude by plain arithmetic, digits by repeated %10.
  task automatic ref_conv(input logic [7:0] v, input int digits,
                          output logic [11:0] bcd, output logic ovf, output logic neg);
    int mag;
    int lim;
`ifdef BCD_SIGNED_EN
    neg = v[7];
    mag = v[7] ? 256 - int'(v) : int'(v);
`else
    neg = 1'b0;
    mag = int'(v);
`endif
    lim = (digits == 3) ? 1000 : 100;
    ovf = (mag >= lim);
    bcd = '0;
    for (int i = 0; i < digits; i++) begin
      bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 3) ? b3.in_ready : b2.in_ready;
  endfunction

  function automatic logic vld(input int sel);
    return (sel == 3) ? b3.out_valid : b2.out_valid;
  endfunction

  // One conversion with out_ready held high; lat counts edges from acceptance to out_valid.
  task automatic conv(input int sel, input logic [7:0] v,
                      output logic [11:0] bcd, output logic ovf, output logic neg, output int lat);
    int n;
    @(negedge clk);
    if (sel == 3) begin b3.bin_in = v; b3.in_valid = 1'b1; b3.out_ready = 1'b1; end
    else          begin b2.bin_in = v; b2.in_valid = 1'b1; b2.out_ready = 1'b1; end
    n = 0;
    while (!rdy(sel) && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    if (sel == 3) b3.in_valid = 1'b0; else b2.in_valid = 1'b0;
    lat = 0;
    while (!vld(sel) && lat < 100) begin @(posedge clk); #1; lat++; end
    if (sel == 3) begin bcd = b3.bcd_out; ovf = b3.ovf; neg = b3.out_neg; end
    else begin bcd = {4'h0, b2.bcd_out}; ovf = b2.ovf; neg = b2.out_neg; end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    logic [11:0] bcd, ebcd;
    logic        ovf, eovf, neg, eneg;
    logic [11:0] hold_bcd;
    logic        hold_ovf;
    int          lat;
    int          seen;
    logic [7:0]  v;

`ifdef BCD_SIGNED_EN
    tbl.push_back('{8'h80, 12'h128, 1'b0, 1'b1});
    tbl.push_back('{8'hF6, 12'h010, 1'b0, 1'b1});
    tbl.push_back('{8'h7F, 12'h127, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 12'h000, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 12'h001, 1'b0, 1'b1});
    tbl.push_back('{8'h9C, 12'h100, 1'b0, 1'b1});
    tbl.push_back('{8'h63, 12'h099, 1'b0, 1'b0});
`else
    tbl.push_back('{8'd255, 12'h255, 1'b0, 1'b0});
    tbl.push_back('{8'd0,   12'h000, 1'b0, 1'b0});
    tbl.push_back('{8'd99,  12'h099, 1'b0, 1'b0});
    tbl.push_back('{8'd100, 12'h100, 1'b0, 1'b0});
    tbl.push_back('{8'd9,   12'h009, 1'b0, 1'b0});
    tbl.push_back('{8'd10,  12'h010, 1'b0, 1'b0});
    tbl.push_back('{8'd128, 12'h128, 1'b0, 1'b0});
    tbl.push_back('{8'd199, 12'h199, 1'b0, 1'b0});
`endif

    b3.in_valid = 1'b0; b3.bin_in = '0; b3.out_ready = 1'b0;
    b2.in_valid = 1'b0; b2.bin_in = '0; b2.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  b3.in_ready,  1'b1);
    chk("rst_out_valid", b3.out_valid, 1'b0);
    chk("rst_bcd",       b3.bcd_out,   12'h000);
    chk("rst_ovf",       b3.ovf,       1'b0);
    chk("rst_neg",       b3.out_neg,   1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      conv(3, tbl[i].bin, bcd, ovf, neg, lat);
      chk($sformatf("tbl%0d_bcd", i), bcd, tbl[i].bcd);
      chk($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
      chk($sformatf("tbl%0d_neg", i), neg, tbl[i].neg);
      chk($sformatf("tbl%0d_lat", i), lat, 8);
      chk($sformatf("tbl%0d_drop", i), b3.out_valid, 1'b0);
    end

    for (int i = 0; i < 256; i++) begin
      v = 8'(i);
      conv(3, v, bcd, ovf, neg, lat);
      ref_conv(v, 3, ebcd, eovf, eneg);
      chk($sformatf("sweep%0d_bcd", i), bcd, ebcd);
      chk($sformatf("sweep%0d_ovf", i), ovf, eovf);
      chk($sformatf("sweep%0d_neg", i), neg, eneg);
    end

    // Backpressure: result must hold while out_ready is low and a new input is offered.
    @(negedge clk);
    b3.bin_in = 8'd123; b3.in_valid = 1'b1; b3.out_ready = 1'b0;
    @(posedge clk); #1;
    b3.in_valid = 1'b0;
    lat = 0;
    while (!b3.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp_lat", lat, 8);
    hold_bcd = b3.bcd_out;
    hold_ovf = b3.ovf;
    ref_conv(8'd123, 3, ebcd, eovf, eneg);
    chk("bp_bcd", hold_bcd, ebcd);
    b3.bin_in = 8'd45; b3.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), b3.out_valid, 1'b1);
      chk($sformatf("bp%0d_ready", c), b3.in_ready, 1'b0);
      chk($sformatf("bp%0d_bcd", c), b3.bcd_out, hold_bcd);
      chk($sformatf("bp%0d_ovf", c), b3.ovf, hold_ovf);
    end
    b3.in_valid = 1'b0;
    b3.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_valid", b3.out_valid, 1'b0);
    chk("bp_rel_ready", b3.in_ready, 1'b1);

    // Reset three cycles into SHIFT aborts the conversion with no result.
    @(negedge clk);
    b3.bin_in = 8'd200; b3.in_valid = 1'b1;
    @(posedge clk); #1;
    b3.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", b3.out_valid, 1'b0);
    chk("arst_ready", b3.in_ready, 1'b1);
    chk("arst_bcd",   b3.bcd_out, 12'h000);
    chk("arst_ovf",   b3.ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b3.out_valid) seen++;
    end
    chk("arst_no_result", seen, 0);
    conv(3, 8'd77, bcd, ovf, neg, lat);
    ref_conv(8'd77, 3, ebcd, eovf, eneg);
    chk("arst_after_bcd", bcd, ebcd);
    chk("arst_after_lat", lat, 8);

    // Two-digit instance: overflow then a clean conversion clears ovf.
    conv(2, 8'd200, bcd, ovf, neg, lat);
    ref_conv(8'd200, 2, ebcd, eovf, eneg);
    chk("d2_200_bcd", bcd, ebcd);
    chk("d2_200_ovf", ovf, eovf);
    chk("d2_200_lat", lat, 8);
    conv(2, 8'd99, bcd, ovf, neg, lat);
    chk("d2_99_bcd", bcd, 12'h099);
    chk("d2_99_ovf", ovf, 1'b0);
`ifndef BCD_SIGNED_EN
    conv(2, 8'd200, bcd, ovf, neg, lat);
    chk("d2_200u_bcd", bcd, 12'h000);
    chk("d2_200u_ovf", ovf, 1'b1);
    conv(2, 8'd100, bcd, ovf, neg, lat);
    chk("d2_100u_bcd", bcd, 12'h000);
    chk("d2_100u_ovf", ovf, 1'b1);
`endif

    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom_range(0, 255));
      conv(2, v, bcd, ovf, neg, lat);
      ref_conv(v, 2, ebcd, eovf, eneg);
      chk($sformatf("d2rnd%0d_bcd_%0h", i, v), bcd, ebcd);
      chk($sformatf("d2rnd%0d_ovf_%0h", i, v), ovf, eovf);
      chk($sformatf("d2rnd%0d_neg_%0h", i, v), neg, eneg);
    end

    for (int i = 0; i < 40; i++) begin
      v = 8'($urandom_range(0, 255));
      conv(3, v, bcd, ovf, neg, lat);
      ref_conv(v, 3, ebcd, eovf, eneg);
      chk($sformatf("d3rnd%0d_bcd_%0h", i, v), bcd, ebcd);
      chk($sformatf("d3rnd%0d_lat_%0h", i, v), lat, 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
